pkt_header_insert: RTL

- Parametrised Avalon-ST header inserter for the packet-parser ingress path. Sits between the MAC-side stream and the NoC injection port.
- Buffers the incoming stream in a first-word-fall-through FIFO and prepends one header beat per packet. The header carries a node ID and a wrapping sequence number.
- Drops orphan beats and terminates malformed (eop-less) packets with an error beat.
- A runtime `hdr_en` input allows pass-through without headers.

---
 rtl/pkt_header_insert.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/pkt_header_insert.sv
// Avalon-ST header inserter: FWFT input FIFO, one header beat per packet, orphan drop, eop-less termination.
// Define PKT_HDR_INSERT_STATS_EN to add the stat_pkts/stat_drops/stat_terms counters and ports.
module pkt_header_insert #(
    parameter int DATA_WIDTH    = 64,
    parameter int FIFO_DEPTH    = 32,
    parameter int NODE_ID       = 7,
    parameter int NODE_ID_WIDTH = 4,
    parameter int SEQ_WIDTH     = 28,
    localparam int EW           = $clog2(DATA_WIDTH / 8)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  hdr_en,
    input  logic                  in_valid,
    input  logic                  in_sop,
    input  logic                  in_eop,
    input  logic                  in_error,
    input  logic [EW-1:0]         in_empty,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic                  out_error,
    output logic [EW-1:0]         out_empty,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready
`ifdef PKT_HDR_INSERT_STATS_EN
    ,
    output logic [31:0]           stat_pkts,
    output logic [15:0]           stat_drops,
    output logic [15:0]           stat_terms
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int WW = DATA_WIDTH + EW + 3;
    localparam logic [AW:0]              USED_MAX  = (AW + 1)'(FIFO_DEPTH - 2);
    localparam logic [AW:0]              PTR_ONE   = (AW + 1)'(1);
    localparam logic [SEQ_WIDTH-1:0]     SEQ_ONE   = SEQ_WIDTH'(1);
    localparam logic [NODE_ID_WIDTH-1:0] NODE_ID_F = NODE_ID_WIDTH'(NODE_ID);
    localparam logic [0:0]               ST_IDLE   = 1'b0;
    localparam logic [0:0]               ST_BODY   = 1'b1;

    logic [WW-1:0]         mem_r [FIFO_DEPTH];
    logic [AW:0]           wr_ptr_r, rd_ptr_r;
    logic [AW:0]           used_s;
    logic                  fifo_empty_s, wr_en_s, pop_s;
    logic [WW-1:0]         head_s;
    logic                  head_sop_s, head_eop_s, head_err_s;
    logic [EW-1:0]         head_empty_s;
    logic [DATA_WIDTH-1:0] head_data_s;
    logic [0:0]            state_r, state_nxt_s;
    logic                  bypass_r, bypass_nxt_s;
    logic                  first_r, first_nxt_s;
    logic                  term_sel_s, seq_inc_s;
    logic [SEQ_WIDTH-1:0]  seq_r;

    function automatic logic [DATA_WIDTH-1:0] make_header(input logic [SEQ_WIDTH-1:0] seq);
        logic [DATA_WIDTH-1:0] h;
        h = {DATA_WIDTH{1'b0}};
        h[DATA_WIDTH-2 -: NODE_ID_WIDTH]             = NODE_ID_F;
        h[DATA_WIDTH-2-NODE_ID_WIDTH -: SEQ_WIDTH]   = seq;
        return h;
    endfunction

    assign used_s       = wr_ptr_r - rd_ptr_r;
    assign fifo_empty_s = (used_s == {(AW + 1){1'b0}});
    // Two-entry slack keeps in_ready a pure function of occupancy
    assign in_ready     = (used_s <= USED_MAX) && !reset;
    assign wr_en_s      = in_valid && in_ready;

    assign head_s       = mem_r[rd_ptr_r[AW-1:0]];
    assign head_sop_s   = head_s[WW-1];
    assign head_eop_s   = head_s[WW-2];
    assign head_err_s   = head_s[WW-3];
    assign head_empty_s = head_s[DATA_WIDTH +: EW];
    assign head_data_s  = head_s[DATA_WIDTH-1:0];

    // A sop at the head after the packet already delivered a beat means its eop was lost
    assign term_sel_s   = (state_r == ST_BODY) && !fifo_empty_s && head_sop_s && !first_r;

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= {in_sop, in_eop, in_error, in_empty, in_data};
        end
    end

    // FIFO pointers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {(AW + 1){1'b0}};
            rd_ptr_r <= {(AW + 1){1'b0}};
        end else begin
            if (wr_en_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_s)   rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end
    end

    // Packet FSM, mode latch and sequence counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            bypass_r <= 1'b0;
            first_r  <= 1'b0;
            seq_r    <= {SEQ_WIDTH{1'b0}};
        end else begin
            state_r  <= state_nxt_s;
            bypass_r <= bypass_nxt_s;
            first_r  <= first_nxt_s;
            if (seq_inc_s) seq_r <= seq_r + SEQ_ONE;
        end
    end

    // Next state, pop and combinational source-side beat
    always_comb begin
        state_nxt_s  = state_r;
        bypass_nxt_s = bypass_r;
        first_nxt_s  = first_r;
        seq_inc_s    = 1'b0;
        pop_s        = 1'b0;
        out_valid    = 1'b0;
        out_sop      = 1'b0;
        out_eop      = 1'b0;
        out_error    = 1'b0;
        out_empty    = {EW{1'b0}};
        out_data     = {DATA_WIDTH{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s && head_sop_s) begin
                    if (hdr_en) begin
                        out_valid = 1'b1;
                        out_sop   = 1'b1;
                        out_data  = make_header(seq_r);
                        if (out_ready) begin
                            seq_inc_s    = 1'b1;
                            state_nxt_s  = ST_BODY;
                            bypass_nxt_s = 1'b0;
                            first_nxt_s  = 1'b1;
                        end else begin
                            state_nxt_s  = ST_IDLE;
                        end
                    end else begin
                        state_nxt_s  = ST_BODY;
                        bypass_nxt_s = 1'b1;
                        first_nxt_s  = 1'b1;
                    end
                end else if (!fifo_empty_s) begin
                    pop_s = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BODY: begin
                if (term_sel_s) begin
                    out_valid = 1'b1;
                    out_eop   = 1'b1;
                    out_error = 1'b1;
                    if (out_ready) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_BODY;
                    end
                end else if (!fifo_empty_s) begin
                    out_valid = 1'b1;
                    out_sop   = bypass_r & head_sop_s;
                    out_eop   = head_eop_s;
                    out_error = head_err_s;
                    out_empty = head_empty_s;
                    out_data  = head_data_s;
                    if (out_ready) begin
                        pop_s       = 1'b1;
                        first_nxt_s = 1'b0;
                        if (head_eop_s) begin
                            state_nxt_s = ST_IDLE;
                        end else begin
                            state_nxt_s = ST_BODY;
                        end
                    end else begin
                        state_nxt_s = ST_BODY;
                    end
                end else begin
                    state_nxt_s = ST_BODY;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

`ifdef PKT_HDR_INSERT_STATS_EN
    logic [31:0] stat_pkts_r;
    logic [15:0] stat_drops_r, stat_terms_r;

    // Statistics: packets wrap, drops and terminations saturate
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_pkts_r  <= 32'd0;
            stat_drops_r <= 16'd0;
            stat_terms_r <= 16'd0;
        end else begin
            if (out_valid && out_ready && out_eop) stat_pkts_r <= stat_pkts_r + 32'd1;
            if (pop_s && (state_r == ST_IDLE) && (stat_drops_r != 16'hFFFF)) stat_drops_r <= stat_drops_r + 16'd1;
            if (term_sel_s && out_ready && (stat_terms_r != 16'hFFFF)) stat_terms_r <= stat_terms_r + 16'd1;
        end
    end

    assign stat_pkts  = stat_pkts_r;
    assign stat_drops = stat_drops_r;
    assign stat_terms = stat_terms_r;
`endif

endmodule
